calc_cmd_scheduler: RTL

- Shares the calculator's single 4-bit `cmd` input between two command sources: requester 0 (keypad) and requester 1 (host/script).
- Arbitrates between the sources, buffers accepted commands in a small FIFO, and issues one command at a time.
- Paces issue on the calculator's `status` handshake (00 error, 01 busy, 10 ready).
- Sits between the input sources and the calculator; owns the calculator's `cmd` pin.

---
 rtl/calc_cmd_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/calc_cmd_scheduler.sv
// calc_cmd_scheduler
//   Shares the calculator's 4-bit cmd input between requester 0 (keypad) and
//   requester 1 (host/script). Accepted commands are queued in a small FIFO
//   as {source, cmd} and issued one at a time, paced by calc_status
//   (00 error, 01 busy, 10 ready).
//
// Ports
//   clock, reset              system clock, asynchronous active-high reset
//   req0_valid/cmd/ready      requester 0 handshake (ready is combinational)
//   req1_valid/cmd/ready      requester 1 handshake (ready is combinational)
//   calc_status               calculator status
//   calc_cmd                  registered command to the calculator
//   clear_err                 leave the error state
//   err                       calculator reported error; scheduler halted
//   timeout                   one-cycle pulse when a command is abandoned
//   busy                      FSM not idle or FIFO non-empty
//   fifo_count                current FIFO occupancy
//   grant_id                  source of the most recently accepted command
//
// Build option
//   FIXED_PRIO_EN             requester 0 always wins; no round-robin pointer
module calc_cmd_scheduler #(
  parameter int          DEPTH   = 4,
  parameter logic [3:0]  NOP_CMD = 4'hD,
  parameter int          TIMEOUT = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [3:0]               req0_cmd,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [3:0]               req1_cmd,
  output logic                     req1_ready,
  input  logic [1:0]               calc_status,
  output logic [3:0]               calc_cmd,
  input  logic                     clear_err,
  output logic                     err,
  output logic                     timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     grant_id
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_READY, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [3:0]         calc_cmd_q, calc_cmd_d;
  logic               timeout_q, timeout_d;
  logic               grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [4:0]         mem_q [DEPTH];

  logic st_err, st_ready, tmo_hit;
  logic can_accept, pick1, push, pop, flush;
  logic [4:0] push_entry, rd_entry;
  logic unused_src;

  assign st_err   = (calc_status == 2'b00);
  assign st_ready = (calc_status == 2'b10);
  assign tmo_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign rd_entry = mem_q[rd_ptr_q];
  assign unused_src = rd_entry[4];

  // Arbitration
`ifdef FIXED_PRIO_EN
  assign pick1 = req1_valid && !req0_valid;
`else
  logic rr_q, rr_d;
  assign pick1 = req1_valid && (!req0_valid || rr_q);
`endif

  assign can_accept = (count_q != (PTR_W+1)'(DEPTH)) && (state_q != S_ERR);
  assign req0_ready = can_accept && req0_valid && !pick1;
  assign req1_ready = can_accept && pick1;
  assign push       = req0_ready || req1_ready;
  assign push_entry = {pick1, pick1 ? req1_cmd : req0_cmd};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; calculator error overrides everything
  always_comb begin
    state_d = state_q;
    if (st_err) begin
      state_d = S_ERR;
    end else begin
      unique case (state_q)
        S_IDLE:       if (count_q != '0 && st_ready) state_d = S_ISSUE;
        S_ISSUE:      if (!st_ready)                 state_d = S_WAIT_READY;
                      else if (tmo_hit)              state_d = S_IDLE;
        S_WAIT_READY: if (st_ready || tmo_hit)       state_d = S_IDLE;
        S_ERR:        if (clear_err)                 state_d = S_IDLE;
        default:                                     state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    pop        = (state_q == S_IDLE) && (state_d == S_ISSUE);
    flush      = (state_d == S_ERR);
    calc_cmd_d = NOP_CMD;
    timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE:       calc_cmd_d = pop ? rd_entry[3:0] : NOP_CMD;
      S_ISSUE: begin
        calc_cmd_d = (state_d == S_ISSUE) ? calc_cmd_q : NOP_CMD;
        timeout_d  = (state_d == S_IDLE);
      end
      // Returning to IDLE without seeing ready can only be the timeout
      S_WAIT_READY: timeout_d = (state_d == S_IDLE) && !st_ready;
      default:      calc_cmd_d = NOP_CMD;
    endcase

    // Counter restarts whenever ISSUE or WAIT_READY is entered
    if ((state_d == S_ISSUE || state_d == S_WAIT_READY) && state_d == state_q)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = '0;

    grant_id_d = push ? pick1 : grant_id_q;
`ifndef FIXED_PRIO_EN
    rr_d = rr_q;
    if (push && req0_valid && req1_valid) rr_d = !pick1;
`endif

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      calc_cmd_q <= NOP_CMD;
      timeout_q  <= 1'b0;
      grant_id_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifndef FIXED_PRIO_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      calc_cmd_q <= calc_cmd_d;
      timeout_q  <= timeout_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifndef FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign calc_cmd   = calc_cmd_q;
  assign timeout    = timeout_q;
  assign grant_id   = grant_id_q;
  assign err        = (state_q == S_ERR);
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule
